pipeline_hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage core (IF/ID/EX/MEM/WB). It sits beside the instruction decoder. It takes the decoded register-usage, destination and load flags for the instruction in ID, and tracks destination tags through EX/MEM/WB in internal shift registers. It generates operand-forwarding selects, load-use stalls, branch flushes and a saturating stall counter.

---
 rtl/pipeline_hazard_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage core: forwarding selects, load-use stall,
// branch flushes and a saturating stall counter, driven by destination tags shadowing EX/MEM/WB.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned DELAY_SLOT = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_r1,
    input  logic [REG_W-1:0] id_r2,
    input  logic [1:0]       id_sr,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_rf_le,
    input  logic             id_load,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic             flush_if,
    output logic             flush_id,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam bit HAS_DELAY_SLOT = (DELAY_SLOT != 0);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    // The load flag only matters while the producer is in EX (its data is not ready yet).
    typedef struct packed {
        logic             v;
        logic             ld;
        logic [REG_W-1:0] rd;
    } ex_tag_t;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
    } tag_t;

    ex_tag_t ex_q;
    tag_t    mem_q;
    tag_t    wb_q;

    logic load_use;

    function automatic logic hits(input logic v, input logic [REG_W-1:0] rd,
                                  input logic [REG_W-1:0] src);
        return v && (rd == src) && (src != '0);
    endfunction

    // Youngest producer wins; an in-flight load in EX has nothing to forward yet.
    function automatic logic [1:0] fwd_sel(input logic use_src, input logic [REG_W-1:0] src,
                                           input ex_tag_t ex, input tag_t mem, input tag_t wb);
        logic [1:0] sel;
        sel = SEL_RF;
        if (use_src) begin
            if (hits(ex.v, ex.rd, src)) begin
                sel = ex.ld ? SEL_RF : SEL_EX;
            end else if (hits(mem.v, mem.rd, src)) begin
                sel = SEL_MEM;
            end else if (hits(wb.v, wb.rd, src)) begin
                sel = SEL_WB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        load_use = 1'b0;
        stall    = 1'b0;
        flush_if = 1'b0;
        flush_id = 1'b0;
        fwd_a    = SEL_RF;
        fwd_b    = SEL_RF;

        load_use = id_valid && ex_q.v && ex_q.ld &&
                   ((id_sr[0] && hits(ex_q.v, ex_q.rd, id_r1)) ||
                    (id_sr[1] && hits(ex_q.v, ex_q.rd, id_r2)));

        if (rst_n) begin
            // A taken branch overrides the stall: ID is either squashed or a delay slot.
            stall    = load_use && !ex_branch_taken;
            flush_if = ex_branch_taken;
            flush_id = (load_use && !ex_branch_taken) || (ex_branch_taken && !HAS_DELAY_SLOT);
            fwd_a    = fwd_sel(id_sr[0], id_r1, ex_q, mem_q, wb_q);
            fwd_b    = fwd_sel(id_sr[1], id_r2, ex_q, mem_q, wb_q);
        end
    end

    // Tag shift register; EX takes a bubble whenever ID is held or squashed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= '{v: ex_q.v, rd: ex_q.rd};
            if (stall || flush_id) begin
                ex_q <= '0;
            end else begin
                ex_q <= '{v: id_valid && id_rf_le, ld: id_load, rd: id_rd};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // With a delay slot, a branch coinciding with a load-use hazard lets stale data into EX.
    delay_slot_hazard_chk: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(HAS_DELAY_SLOT && ex_branch_taken && load_use)
    );

endmodule
